// File: rtl/cntr_nbit_updown_fsm.sv
// -----------------------------------------------------------------------------
// cntr_nbit_updown_fsm
//
// Purpose:
//   WIDTH-bit up/down counter that advances only on a single-cycle TICK
//   strobe. It runs on the board clock and feeds the seven-segment driver.
//   Three stepping modes are supported: all values, even-only and odd-only.
//   In the even/odd modes an off-parity count takes a single step first, so
//   the count lands on the requested parity.
//   Edge priority: RST > LOAD > HOLD > TICK step > idle.
//
// Build option:
//   CNTR_BOUNCE_EN  undefined : wrap-around counting, and UP selects the
//                               direction on every step.
//                   defined   : ping-pong counting. A two-state direction FSM
//                               (S_UP/S_DN) reflects the count at either end.
//                               UP is sampled only on LOAD.
//
// Parameters:
//   WIDTH    count width in bits (>= 2)
//   RST_VAL  count value loaded on reset
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST     in   synchronous reset, active high
//   TICK    in   advance strobe
//   HOLD    in   freeze count (TICK ignored)
//   UP      in   direction (1 = up)
//   EVEN    in   even-only mode select
//   ODD     in   odd-only mode select
//   LOAD    in   synchronous load of LD_VAL
//   LD_VAL  in   load value
//   moore   out  registered count
//   mealy   out  value moore takes at the next rising edge
//   TC      out  registered one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module cntr_nbit_updown_fsm #(
    parameter int unsigned      WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TICK,
    input  logic             HOLD,
    input  logic             UP,
    input  logic             EVEN,
    input  logic             ODD,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LD_VAL,
    output logic [WIDTH-1:0] moore,
    output logic [WIDTH-1:0] mealy,
    output logic             TC
);

    logic [WIDTH-1:0] moore_q, moore_d;
    logic             tc_q, tc_d;

    // Step size. The step is 2 only when exactly one parity mode is selected
    // and the count already has that parity. Otherwise the step is 1, which
    // also moves an off-parity count onto the selected parity.
    logic             step_two;
    logic [WIDTH:0]   step_w;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic             wrap_up;
    logic             wrap_dn;
    logic             adv;

    always_comb begin
        step_two = (EVEN ^ ODD) & ((EVEN & ~moore_q[0]) | (ODD & moore_q[0]));
        step_w   = {{(WIDTH-1){1'b0}}, step_two, ~step_two};
        // One extra bit exposes the carry out (wrap above max) and the
        // borrow (wrap below 0) directly.
        up_sum   = {1'b0, moore_q} + step_w;
        dn_diff  = {1'b0, moore_q} - step_w;
        wrap_up  = up_sum[WIDTH];
        wrap_dn  = dn_diff[WIDTH];
        adv      = TICK & ~HOLD;
    end

`ifdef CNTR_BOUNCE_EN

    typedef enum logic {S_UP = 1'b0, S_DN = 1'b1} dir_e;

    dir_e dir_q, dir_d;

    always_comb begin
        moore_d = moore_q;
        tc_d    = 1'b0;
        dir_d   = dir_q;
        if (RST) begin
            moore_d = RST_VAL;
            dir_d   = S_UP;
        end else if (LOAD) begin
            moore_d = LD_VAL;
            dir_d   = UP ? S_UP : S_DN;
        end else if (adv) begin
            if (dir_q == S_UP) begin
                if (!wrap_up) begin
                    moore_d = up_sum[WIDTH-1:0];
                end else begin
                    // Reflect off the top. If the step down is also out of
                    // range, hold the count and only turn around.
                    if (!wrap_dn) moore_d = dn_diff[WIDTH-1:0];
                    dir_d = S_DN;
                    tc_d  = 1'b1;
                end
            end else begin
                if (!wrap_dn) begin
                    moore_d = dn_diff[WIDTH-1:0];
                end else begin
                    if (!wrap_up) moore_d = up_sum[WIDTH-1:0];
                    dir_d = S_UP;
                    tc_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            moore_q <= RST_VAL;
            tc_q    <= 1'b0;
            dir_q   <= S_UP;
        end else begin
            moore_q <= moore_d;
            tc_q    <= tc_d;
            dir_q   <= dir_d;
        end
    end

`else

    always_comb begin
        moore_d = moore_q;
        tc_d    = 1'b0;
        if (RST) begin
            moore_d = RST_VAL;
        end else if (LOAD) begin
            moore_d = LD_VAL;
        end else if (adv) begin
            // The modulus 2^WIDTH is even, so a wrap keeps the parity.
            if (UP) begin
                moore_d = up_sum[WIDTH-1:0];
                tc_d    = wrap_up;
            end else begin
                moore_d = dn_diff[WIDTH-1:0];
                tc_d    = wrap_dn;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            moore_q <= RST_VAL;
            tc_q    <= 1'b0;
        end else begin
            moore_q <= moore_d;
            tc_q    <= tc_d;
        end
    end

`endif

    assign moore = moore_q;
    assign mealy = moore_d;
    assign TC    = tc_q;

endmodule

// File: tb/tb_cntr_nbit_updown_fsm.sv
module tb_cntr_nbit_updown_fsm;

    localparam int               WIDTH   = 3;
    localparam logic [WIDTH-1:0] RST_VAL = '0;
    localparam int               MODV    = 1 << WIDTH;
    localparam int               MAXV    = MODV - 1;

    logic             CLK = 1'b0;
    logic             RST, TICK, HOLD, UP, EVEN, ODD, LOAD;
    logic [WIDTH-1:0] LD_VAL;
    logic [WIDTH-1:0] moore, mealy;
    logic             TC;

    int n_chk = 0;
    int n_err = 0;

    // reference state: count value and direction (1 = up), bounce build only
    int m_cnt = 0;
    int m_dir = 1;

    cntr_nbit_updown_fsm #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .HOLD(HOLD), .UP(UP),
        .EVEN(EVEN), .ODD(ODD), .LOAD(LOAD), .LD_VAL(LD_VAL),
        .moore(moore), .mealy(mealy), .TC(TC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic over the range 0..MAXV
    task automatic model(input bit rst, tick, hold, up, even, odd, load,
                         input int ld, output int nxt, output int tc,
                         output int dir);
        int st;
        nxt = m_cnt; tc = 0; dir = m_dir;
        if (rst) begin
            nxt = int'(RST_VAL); dir = 1;
        end else if (load) begin
            nxt = ld; dir = up ? 1 : 0;
        end else if (tick && !hold) begin
            st = 1;
            if (even && !odd && (m_cnt % 2 == 0)) st = 2;
            if (odd && !even && (m_cnt % 2 == 1)) st = 2;
`ifdef CNTR_BOUNCE_EN
            if (m_dir == 1) begin
                if (m_cnt + st <= MAXV) nxt = m_cnt + st;
                else begin
                    if (m_cnt - st >= 0) nxt = m_cnt - st;
                    dir = 0; tc = 1;
                end
            end else begin
                if (m_cnt - st >= 0) nxt = m_cnt - st;
                else begin
                    if (m_cnt + st <= MAXV) nxt = m_cnt + st;
                    dir = 1; tc = 1;
                end
            end
`else
            if (up) begin
                tc  = (m_cnt + st > MAXV) ? 1 : 0;
                nxt = (m_cnt + st) % MODV;
            end else begin
                tc  = (m_cnt - st < 0) ? 1 : 0;
                nxt = (m_cnt - st + MODV) % MODV;
            end
`endif
        end
    endtask

    // Apply one cycle of inputs. mealy is checked before the edge;
    // moore and TC are checked 1 time unit after the edge.
    task automatic cyc(input bit rst, tick, hold, up, even, odd, load,
                       input int ld);
        int nxt, tc, dir;
        RST = rst; TICK = tick; HOLD = hold; UP = up;
        EVEN = even; ODD = odd; LOAD = load; LD_VAL = ld[WIDTH-1:0];
        model(rst, tick, hold, up, even, odd, load, ld, nxt, tc, dir);
        #1;
        chk("mealy", int'(mealy), nxt);
        @(posedge CLK);
        #1;
        m_cnt = nxt; m_dir = dir;
        chk("moore", int'(moore), nxt);
        chk("tc", int'(TC), tc);
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        // reset held for two cycles
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("rst_moore", int'(moore), 0);
        chk("rst_tc", int'(TC), 0);

`ifndef CNTR_BOUNCE_EN
        // ALL mode, counting up through the wrap
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 1, 0, 0, 0, 0);
            chk("all_up", int'(moore), i % 8);
            chk("all_up_tc", int'(TC), (i == 8) ? 1 : 0);
        end
        // EVEN mode up from 3: sequence 4,6,0,2 with TC on 6->0
        begin
            int e_v[4] = '{4, 6, 0, 2};
            int e_t[4] = '{0, 0, 1, 0};
            cyc(0, 0, 0, 1, 0, 0, 1, 3);
            for (int i = 0; i < 4; i++) begin
                cyc(0, 1, 0, 1, 1, 0, 0, 0);
                chk("even_up", int'(moore), e_v[i]);
                chk("even_up_tc", int'(TC), e_t[i]);
            end
        end
        // ODD mode down from 0: sequence 7,5,3; then HOLD with TICK high
        begin
            int o_v[3] = '{7, 5, 3};
            int o_t[3] = '{1, 0, 0};
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            for (int i = 0; i < 3; i++) begin
                cyc(0, 1, 0, 0, 0, 1, 0, 0);
                chk("odd_dn", int'(moore), o_v[i]);
                chk("odd_dn_tc", int'(TC), o_t[i]);
            end
            for (int i = 0; i < 3; i++) begin
                cyc(0, 1, 1, 0, 0, 1, 0, 0);
                chk("hold", int'(moore), 3);
                chk("hold_tc", int'(TC), 0);
            end
        end
`else
        // bounce build: LOAD 6 going up, EVEN mode -> 4,2,0,2
        begin
            int b_v[4] = '{4, 2, 0, 2};
            int b_t[4] = '{1, 0, 0, 1};
            cyc(0, 0, 0, 1, 0, 0, 1, 6);
            for (int i = 0; i < 4; i++) begin
                cyc(0, 1, 0, 0, 1, 0, 0, 0);
                chk("bounce", int'(moore), b_v[i]);
                chk("bounce_tc", int'(TC), b_t[i]);
            end
        end
`endif
        // LOAD wins over TICK; RST wins over LOAD
        cyc(0, 1, 0, 1, 0, 0, 1, 5);
        chk("load_tick", int'(moore), 5);
        cyc(1, 1, 0, 1, 0, 0, 1, 6);
        chk("rst_load", int'(moore), int'(RST_VAL));
        // reset in the middle of a tick stream at count 5
        cyc(0, 1, 0, 1, 0, 0, 1, 5);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        chk("rst_mid", int'(moore), 0);
        chk("rst_mid_tc", int'(TC), 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        chk("resume", int'(moore), 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
                1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom % 10) == 0, int'($urandom % MODV));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cntr_nbit_updown_fsm.md
Name: cntr_nbit_updown_fsm

Overview:
- Parametrised N-bit up/down counter FSM with hold, synchronous load and three stepping modes (all / even-only / odd-only).
- Provides a registered (Moore) count and a combinational (Mealy) next-count.
- Advances only on a single-cycle tick strobe, so the whole design runs on the board clock instead of a divided clock.
- Sits between a tick generator and the univ_sseg display driver in the counter top level.

Parameters:
- WIDTH, 3, count width in bits (>=2); the count range is 0..2^WIDTH-1.
- RST_VAL, 0, count value loaded on reset.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- TICK  in  1  advance strobe; the counter may step only on cycles where TICK=1.
- HOLD  in  1  1 = freeze count (TICK is ignored).
- UP  in  1  direction: 1 = up, 0 = down.
- EVEN  in  1  even-only mode select.
- ODD  in  1  odd-only mode select.
- LOAD  in  1  synchronous load of LD_VAL.
- LD_VAL  in  WIDTH  load value.
- moore  out  WIDTH  registered count.
- mealy  out  WIDTH  combinational value that moore will take at the next rising edge.
- TC  out  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset: on RST=1 at an edge, moore<=RST_VAL, TC<=0, and the direction state<=S_UP (bounce builds only). Reset overrides everything, including mid-step and mid-load.
- Priority at each edge, highest first: RST > LOAD > HOLD > TICK step > idle.
- LOAD: moore<=LD_VAL on that edge whether or not TICK is high; TC<=0.
- HOLD=1 or TICK=0: moore unchanged; TC<=0.
- Mode decode:
  - EVEN XOR ODD = 0 (neither or both set): ALL mode, step = 1.
  - EVEN only: step = 2 if moore is even, else step = 1 (realigns onto an even value).
  - ODD only: step = 2 if moore is odd, else step = 1.
- Step, non-bounce build:
  - UP=1: next = (moore + step) mod 2^WIDTH.
  - UP=0: next = (moore - step) mod 2^WIDTH.
  - Parity is preserved across wrap because 2^WIDTH is even.
- TC: goes high for exactly one cycle, on the edge after a step that wrapped.
  - Wrapping up means moore+step > 2^WIDTH-1.
  - Wrapping down means moore < step.
- mealy: equals the value moore will take at the next edge under the current inputs, including RST, LOAD and HOLD. Example: mealy = RST_VAL whenever RST=1.
- Mode or direction changes take effect on the next TICK; no extra latency.
- Latency: 1 clock from a qualified TICK to the updated moore.

Optional Feature:
- Macro: CNTR_BOUNCE_EN.
- Undefined: wrap-around counting as described above; UP selects direction directly; no direction state.
- Defined: ping-pong counting with a 2-state direction FSM (S_UP, S_DN).
  - UP is sampled only on LOAD: state<=S_UP if UP=1, else S_DN. Otherwise UP is ignored.
  - In S_UP: if moore+step <= 2^WIDTH-1, next = moore+step. Otherwise next = moore-step, state<=S_DN, and TC pulses.
  - S_DN behaves symmetrically at 0.
  - If both moore+step and moore-step are out of range, moore holds, the state flips and TC pulses.
  - Reset puts the FSM in S_UP.

Test Plan:
- RST=1 for 2 cycles, then TICK every cycle, UP=1, ALL mode, WIDTH=3 -> moore sequence 0,1,..,7,0; TC high for one cycle after the 7->0 step.
- Preset moore=3, set EVEN=1, UP=1, apply 4 ticks -> 4,6,0,2; TC pulses once (at 6->0); mealy leads moore by one edge.
- Preset moore=0, set ODD=1, UP=0, apply 3 ticks -> 7,5,3; HOLD=1 with TICK=1 for 3 cycles -> moore stays 3 and TC stays 0.
- LOAD=1 with LD_VAL=5 and TICK=1 in the same cycle -> moore=5 (no step); RST and LOAD together -> moore=RST_VAL.
- With CNTR_BOUNCE_EN defined: LOAD 6 with UP=1, EVEN=1, apply 4 ticks -> 4,2,0,2; TC pulses at the reflection 6->4 and again at 0->2.
- Assert RST during a stream of ticks at count 5 -> next moore=0, TC=0; counting resumes from 0 on the next tick.
